alu_sequencer: RTL and testbench

- Instruction-driven controller for the 6-bit ring ALU.
- Accepts instructions through a valid/ready port and buffers them in a small FIFO.
- Owns a register file that feeds ALU operands. Drives the ALU's x/y/op, captures z and the BAF/IOF/ZF flags, writes results back, and presents each result on a valid/ready output port.
- Sits between the instruction source (UI or test driver) and the combinational ALU instance.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 6-bit ring ALU: buffers instructions in a FIFO,
// feeds registered operands to the ALU, writes back results and returns them on a valid/ready port.
module alu_sequencer #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NREGS      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [3:0]               instr_op,
    input  logic [$clog2(NREGS)-1:0] instr_rd,
    input  logic [$clog2(NREGS)-1:0] instr_rs1,
    input  logic [$clog2(NREGS)-1:0] instr_rs2,
    input  logic                     instr_imm_sel,
    input  logic [WIDTH-1:0]         instr_imm,
    output logic [WIDTH-1:0]         alu_x,
    output logic [WIDTH-1:0]         alu_y,
    output logic [3:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_z,
    input  logic                     alu_baf,
    input  logic                     alu_iof,
    input  logic                     alu_zf,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [2:0]               res_flags,
    output logic                     busy,
    output logic                     err_sticky,
    input  logic                     err_clr
);

    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 4 + 3 * RW + 1 + WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [EW-1:0]    fifo_q [FIFO_DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic             empty, full, push, pop;

    logic [3:0]       h_op;
    logic [RW-1:0]    h_rd, h_rs1, h_rs2;
    logic             h_sel;
    logic [WIDTH-1:0] h_imm;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] x_q, y_q, rs1val_q;
    logic [3:0]       op_q;
    logic [RW-1:0]    rd_q;
    logic [WIDTH-1:0] res_data_q;
    logic [2:0]       res_flags_q;
    logic             err_q;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push  = instr_valid && !full;
    assign instr_ready = !full;

    assign {h_op, h_rd, h_rs1, h_rs2, h_sel, h_imm} = fifo_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= {instr_op, instr_rd, instr_rs1, instr_rs2,
                                         instr_imm_sel, instr_imm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (res_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1val_q <= '0;
        end else begin
            state_q <= state_d;
            // Writeback lands at the end of EXEC, so a pop always reads committed values.
            if (pop) begin
                x_q      <= regs_q[h_rs1];
                y_q      <= h_sel ? h_imm : regs_q[h_rs2];
                op_q     <= h_op;
                rd_q     <= h_rd;
                rs1val_q <= regs_q[h_rs1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else if (state_q == EXEC) begin
            res_flags_q <= {alu_baf, alu_iof, alu_zf};
            if (alu_baf) begin
                res_data_q <= alu_z;
            end else if (alu_iof) begin
                res_data_q <= rs1val_q;
            end else begin
                res_data_q   <= alu_z;
                regs_q[rd_q] <= alu_z;
            end
        end
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == EXEC && alu_baf) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign alu_op     = op_q;
    assign res_valid  = (state_q == RESP);
    assign res_data   = res_data_q;
    assign res_flags  = res_flags_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a ring-ALU model drives the ALU inputs, and an
// in-order architectural model predicts every result the sequencer returns.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = '0;
    logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic       instr_imm_sel = 1'b0;
    logic [5:0] instr_imm = '0;
    logic [5:0] alu_x, alu_y, alu_z;
    logic [3:0] alu_op;
    logic       alu_baf, alu_iof, alu_zf;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [5:0] res_data;
    logic [2:0] res_flags;
    logic       busy, err_sticky;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(6), .FIFO_DEPTH(4), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
        .alu_baf(alu_baf), .alu_iof(alu_iof), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    // Ring ALU: results wrap modulo 32; any operand >= 32 raises BAF.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [5:0] x,
                                         input logic [5:0] y);
        int xi, yi, zi;
        logic baf, iof;
        logic [5:0] z;
        xi = int'(x);
        yi = int'(y);
        baf = (xi >= 32) || (yi >= 32);
        iof = 1'b0;
        case (op)
            4'b0001: begin zi = 0; iof = 1'b1; end
            4'b1010: begin zi = xi + yi; if (zi >= 32) zi -= 32; end
            4'b1000: begin zi = xi + 1;  if (zi >= 32) zi -= 32; end
            4'b1011: begin zi = xi - yi; if (zi < 0) zi += 32; end
            default: zi = (xi ^ yi) % 32;
        endcase
        z = zi[5:0];
        return {z, baf, iof, z == 6'd0};
    endfunction

    always_comb {alu_z, alu_baf, alu_iof, alu_zf} = alu_f(alu_op, alu_x, alu_y);

    typedef struct packed {
        logic [5:0] d;
        logic [2:0] f;
    } res_t;

    res_t       exp_q[$];
    res_t       got_q[$];
    int         hs_time[$];
    logic [5:0] mregs[4];
    int         total = 0, bad = 0;
    int         acc_cnt = 0, hs_cnt = 0, cyc = 0;
    logic       rnd_rr = 1'b0;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Architectural model: instructions retire in program order against mregs.
    function automatic void model_push(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic sel, input logic [5:0] imm);
        logic [5:0] x, y, d;
        logic [8:0] r;
        x = mregs[rs1];
        y = sel ? imm : mregs[rs2];
        r = alu_f(op, x, y);
        if (r[2])      d = r[8:3];
        else if (r[1]) d = x;
        else begin
            mregs[rd] = r[8:3];
            d = r[8:3];
        end
        exp_q.push_back({d, r[2:0]});
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        acc_cnt = 0;
        hs_cnt  = 0;
        for (int i = 0; i < 4; i++) mregs[i] = '0;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            if (instr_valid && instr_ready) acc_cnt++;
            if (res_valid && res_ready) begin
                hs_cnt++;
                got_q.push_back({res_data, res_flags});
                hs_time.push_back(cyc);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", int'(busy), int'(acc_cnt != hs_cnt));
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("res_data", int'(res_data), int'(exp_q[0].d));
                    check("res_flags", int'(res_flags), int'(exp_q[0].f));
                    if (exp_q[0].f[2]) check("err_on_baf", int'(err_sticky), 1);
                end
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic sel, input logic [5:0] imm);
        int n = 0;
        @(negedge clk);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_imm_sel = sel; instr_imm = imm; instr_valid = 1'b1;
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check("push_timeout", 0, 1);
            instr_valid = 1'b0;
        end else begin
            model_push(op, rd, rs1, rs2, sel, imm);
            @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic read_reg(input logic [1:0] r);
        push(4'b0001, 2'd0, r, 2'd0, 1'b0, 6'd0);
    endtask

    initial begin
        logic [5:0] d0;
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [5:0] held;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_flags", int'(res_flags), 0);
        check("rst_err", int'(err_sticky), 0);
        check("rst_alu_x", int'(alu_x), 0);
        check("rst_alu_y", int'(alu_y), 0);
        check("rst_alu_op", int'(alu_op), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_instr_ready", int'(instr_ready), 1);

        // Wrap: 20 + 15 = 35 wraps to 3
        got_q.delete();
        push(4'b1010, 2'd1, 2'd0, 2'd0, 1'b1, 6'd20);
        push(4'b1010, 2'd2, 2'd1, 2'd0, 1'b1, 6'd15);
        read_reg(2'd2);
        wait_idle();
        check("wrap_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("wrap_r1", int'(got_q[0].d), 20);
            check("wrap_r1_flags", int'(got_q[0].f), 0);
            check("wrap_r2", int'(got_q[1].d), 3);
            check("wrap_r2_flags", int'(got_q[1].f), 0);
            check("wrap_r2_read", int'(got_q[2].d), 3);
        end

        // IOF: returns rs1 value, no writeback to rd
        got_q.delete();
        push(4'b0001, 2'd2, 2'd1, 2'd0, 1'b0, 6'd0);
        read_reg(2'd2);
        wait_idle();
        if (got_q.size() == 2) begin
            check("iof_data", int'(got_q[0].d), 20);
            check("iof_flags", int'(got_q[0].f), 3'b011);
            check("iof_r2_kept", int'(got_q[1].d), 3);
        end else check("iof_count", got_q.size(), 2);

        // BAF: immediate 40 out of bounds
        got_q.delete();
        push(4'b1010, 2'd3, 2'd0, 2'd0, 1'b1, 6'd40);
        wait_idle();
        check("baf_err", int'(err_sticky), 1);
        read_reg(2'd3);
        wait_idle();
        if (got_q.size() == 2) begin
            check("baf_flag", int'(got_q[0].f[2]), 1);
            check("baf_r3_kept", int'(got_q[1].d), 0);
        end else check("baf_count", got_q.size(), 2);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("err_clr", int'(err_sticky), 0);
        push(4'b1010, 2'd3, 2'd0, 2'd0, 1'b1, 6'd50);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_set_beats_clr", int'(err_sticky), 1);
        wait_idle();

        // Dependency chain, back-to-back, one result every 2 cycles
        got_q.delete();
        hs_time.delete();
        push(4'b1010, 2'd1, 2'd0, 2'd0, 1'b1, 6'd5);
        push(4'b1000, 2'd2, 2'd1, 2'd0, 1'b0, 6'd0);
        push(4'b1011, 2'd3, 2'd2, 2'd1, 1'b0, 6'd0);
        wait_idle();
        if (got_q.size() == 3 && hs_time.size() == 3) begin
            check("dep_a", int'(got_q[0].d), 5);
            check("dep_b", int'(got_q[1].d), 6);
            check("dep_c", int'(got_q[2].d), 1);
            check("dep_rate_ab", hs_time[1] - hs_time[0], 2);
            check("dep_rate_bc", hs_time[2] - hs_time[1], 2);
        end else check("dep_count", got_q.size(), 3);

        // Backpressure: 1 in RESP + 4 queued, then the 6th waits
        got_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'b1010, 2'd1, 2'd0, 2'd0, 1'b1, 6'(i + 1));
        @(negedge clk);
        check("bp_full_ready", int'(instr_ready), 0);
        check("bp_res_valid", int'(res_valid), 1);
        held = res_data;
        repeat (4) begin
            @(negedge clk);
            check("bp_hold", int'(res_data), int'(held));
        end
        fork
            push(4'b1010, 2'd1, 2'd0, 2'd0, 1'b1, 6'd6);
            begin
                repeat (3) @(negedge clk);
                res_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) check("bp_order", int'(got_q[i].d), i + 1);

        // Reset during EXEC with two instructions queued
        res_ready = 1'b0;
        push(4'b1010, 2'd1, 2'd0, 2'd0, 1'b1, 6'd7);
        push(4'b1010, 2'd2, 2'd0, 2'd0, 1'b1, 6'd9);
        push(4'b1010, 2'd3, 2'd0, 2'd0, 1'b1, 6'd11);
        push(4'b1010, 2'd0, 2'd0, 2'd0, 1'b1, 6'd13);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("pre_rst_alu_y", int'(alu_y), 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", int'(res_valid), 0);
        check("mid_rst_alu_x", int'(alu_x), 0);
        check("mid_rst_alu_y", int'(alu_y), 0);
        check("mid_rst_alu_op", int'(alu_op), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        got_q.delete();
        for (int r = 0; r < 4; r++) read_reg(2'(r));
        wait_idle();
        check("post_rst_count", got_q.size(), 4);
        for (int r = 0; r < 4 && r < got_q.size(); r++) check("post_rst_reg", int'(got_q[r].d), 0);

        // Randomised traffic with random result backpressure
        rnd_rr = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [3:0] op;
                    logic [5:0] imm;
                    case ($urandom_range(0, 4))
                        0: op = 4'b0001;
                        1: op = 4'b1010;
                        2: op = 4'b1000;
                        3: op = 4'b1011;
                        default: op = 4'($urandom_range(0, 15));
                    endcase
                    imm = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63))
                                                      : 6'($urandom_range(0, 31));
                    push(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm);
                end
                rnd_rr = 1'b0;
            end
            begin
                while (rnd_rr) begin
                    @(negedge clk);
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
